datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The module SHALL run on one clock and use an asynchronous, active-low reset, with ports named as follows.
- clock  in  1  rising-edge clock for all registers
- clear  in  1  asynchronous active-low reset
REQ-002 The module SHALL provide these bus-source selects, each an active-high input:
- PCout, Zlowout, MDRout, R2out, R3out  in  1 each
REQ-003 The module SHALL provide these register load enables, each an active-high input:
- MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in  in  1 each
REQ-004 The module SHALL provide these control inputs:
- IncPC  in  1  ALU increment
- AND  in  1  ALU bitwise AND
- Read  in  1  MDR source select
REQ-005 The module SHALL provide this data input:
- Mdatain  in  32  memory data input
REQ-006 The module SHALL provide these observation outputs:
- BusMuxOut  out  32  current bus value
- R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q  out  32 each  register contents

Function
REQ-007 BusMuxOut SHALL be combinational.
- Source priority: Zlowout > MDRout > PCout > R2out > R3out.
- When no select is asserted, BusMuxOut SHALL be 0.
REQ-008 Each register SHALL load on the rising clock edge while its enable is high, and SHALL hold its value otherwise.
- R1, R2, R3, PC, IR, MAR and Y load from BusMuxOut.
REQ-009 The MDR input SHALL be Mdatain when Read=1 and BusMuxOut when Read=0; MDR loads only when MDRin=1.
REQ-010 The ALU SHALL be combinational on operands Y and BusMuxOut, with this priority:
- IncPC=1: result = BusMuxOut + 1, modulo 2^32.
- else AND=1: result = Y & BusMuxOut.
- else: see REQ-020.
REQ-011 Z SHALL be 64 bits.
- When Zin=1, Zlow loads the ALU result and Zhigh loads 0 on the rising edge.
REQ-012 Increment SHALL wrap: 0xFFFFFFFF + 1 gives Zlow = 0x00000000 and Zhigh = 0.
REQ-013 A register that drives the bus and loads in the same cycle SHALL capture the pre-edge bus value, with no combinational loop through registers.
REQ-014 Load latency SHALL be one clock edge; values SHALL be visible on the *_q outputs immediately after that edge.

Reset
REQ-015 While clear=0, all registers SHALL be 0, independent of clock.
- Registers: R1, R2, R3, PC, IR, MAR, MDR, Y, Zlow, Zhigh.
REQ-016 Asserting clear mid-operation SHALL override any pending load.
REQ-017 After clear rises, registers SHALL resume loading from the next rising edge.
REQ-018 BusMuxOut SHALL remain combinational during reset and reflect the zeroed registers.

Configuration
REQ-019 Macro DATAPATH_ADD_EN SHALL control the ALU default operation.
REQ-020 The ALU default operation (IncPC=0, AND=0) SHALL depend on DATAPATH_ADD_EN.
- Defined: result = Y + BusMuxOut, modulo 2^32.
- Undefined: result = 0.

Verification
REQ-021 Register preload:
- Read=1, MDRin=1, Mdatain=0x12 for one edge; then MDRout=1, R2in=1 for one edge -> R2_q=0x12.
- Repeat for R3=0x14 and R1=0x18.
REQ-022 Fetch sequence:
- From PC=0, apply PCout+MARin+IncPC+Zin -> MAR_q=0, Zlow_q=1.
- Then Zlowout+PCin+Read+MDRin with Mdatain=0x28918000 -> PC_q=1, MDR_q=0x28918000.
- Then MDRout+IRin -> IR_q=0x28918000.
REQ-023 AND execute, with R2=0x12 and R3=0x14:
- R2out+Yin -> Y_q=0x12.
- R3out+AND+Zin -> Zlow_q=0x10.
- Zlowout+R1in -> R1_q=0x10.
REQ-024 Bus priority and idle bus:
- MDRout, PCout and R2out asserted together -> BusMuxOut=MDR.
- No select asserted -> BusMuxOut=0.
REQ-025 Increment wrap: PC=0xFFFFFFFF, then PCout+IncPC+Zin -> Zlow_q=0, Zhigh_q=0.
REQ-026 Asynchronous reset:
- Pulse clear=0 between clock edges after loads -> all *_q outputs=0 immediately.
- Loads resume on the next edge after clear rises.
REQ-027 Configuration check: Y=3, bus=4, IncPC=0, AND=0, Zin=1 -> Zlow_q=7 with DATAPATH_ADD_EN defined, and 0 without it.

Source files
------------

// File: rtl/datapath_if.sv
// datapath_if: control selects, load enables, memory data and register observation bus for datapath.
interface datapath_if;
    logic        PCout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in;
    logic        IncPC, AND, Read;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;
    logic [31:0] R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q;
    modport master (
        output PCout, Zlowout, MDRout, R2out, R3out,
        output MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
        output IncPC, AND, Read, Mdatain,
        input  BusMuxOut,
        input  R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q
    );
    modport slave (
        input  PCout, Zlowout, MDRout, R2out, R3out,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
        input  IncPC, AND, Read, Mdatain,
        output BusMuxOut,
        output R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q
    );
endinterface

// File: rtl/datapath.sv
// datapath: single-bus register file, MDR, Y/Z and ALU (increment, AND, optional add).
// Define DATAPATH_ADD_EN to make the ALU default operation Y + bus instead of 0.
module datapath (
    input  logic       clock,
    input  logic       clear,
    datapath_if.slave  dp
);
    logic [31:0] r_r1, r_r2, r_r3, r_pc, r_ir, r_mar, r_mdr, r_y, r_zlow, r_zhigh;
    logic [31:0] w_bus, w_alu, w_mdr_d;
    // Bus sources only come from registers, so a drive-and-load in one cycle sees the pre-edge value.
    always_comb begin
        w_bus = dp.Zlowout ? r_zlow :
                dp.MDRout  ? r_mdr  :
                dp.PCout   ? r_pc   :
                dp.R2out   ? r_r2   :
                dp.R3out   ? r_r3   : '0;
    end
    always_comb begin
`ifdef DATAPATH_ADD_EN
        w_alu = dp.IncPC ? w_bus + 32'd1 : dp.AND ? (r_y & w_bus) : r_y + w_bus;
`else
        w_alu = dp.IncPC ? w_bus + 32'd1 : dp.AND ? (r_y & w_bus) : '0;
`endif
    end
    assign w_mdr_d = dp.Read ? dp.Mdatain : w_bus;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_r1    <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_y     <= '0;
            r_zlow  <= '0;
            r_zhigh <= '0;
        end else begin
            if (dp.R1in)  r_r1  <= w_bus;
            if (dp.R2in)  r_r2  <= w_bus;
            if (dp.R3in)  r_r3  <= w_bus;
            if (dp.PCin)  r_pc  <= w_bus;
            if (dp.IRin)  r_ir  <= w_bus;
            if (dp.MARin) r_mar <= w_bus;
            if (dp.Yin)   r_y   <= w_bus;
            if (dp.MDRin) r_mdr <= w_mdr_d;
            if (dp.Zin) begin
                r_zlow  <= w_alu;
                r_zhigh <= '0;
            end
        end
    end
    assign dp.BusMuxOut = w_bus;
    assign dp.R1_q      = r_r1;
    assign dp.R2_q      = r_r2;
    assign dp.R3_q      = r_r3;
    assign dp.PC_q      = r_pc;
    assign dp.IR_q      = r_ir;
    assign dp.MAR_q     = r_mar;
    assign dp.MDR_q     = r_mdr;
    assign dp.Y_q       = r_y;
    assign dp.Zlow_q    = r_zlow;
    assign dp.Zhigh_q   = r_zhigh;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: vector table driven through a scoreboard queue, plus async-reset sequence.
module tb_datapath;
    logic clock, clear;
    datapath_if bus ();
    datapath u_dut (.clock(clock), .clear(clear), .dp(bus));

    localparam logic [16:0] PCOUT = 17'd1 << 16, ZLOUT = 17'd1 << 15, MDROUT = 17'd1 << 14,
        R2OUT = 17'd1 << 13, R3OUT = 17'd1 << 12, MARIN = 17'd1 << 11, ZIN = 17'd1 << 10,
        PCIN = 17'd1 << 9, MDRIN = 17'd1 << 8, IRIN = 17'd1 << 7, YIN = 17'd1 << 6,
        R1IN = 17'd1 << 5, R2IN = 17'd1 << 4, R3IN = 17'd1 << 3, INCPC = 17'd1 << 2,
        ANDC = 17'd1 << 1, READ = 17'd1;
    localparam int S_R1 = 0, S_R2 = 1, S_R3 = 2, S_PC = 3, S_IR = 4, S_MAR = 5, S_MDR = 6,
        S_Y = 7, S_ZL = 8, S_ZH = 9, S_BUS = 10, NONE = -1;

    typedef struct {
        logic [16:0] ctrl;
        logic [31:0] md;
        int          s1;
        logic [31:0] e1;
        int          s2;
        logic [31:0] e2;
    } vec_t;
    typedef struct {
        int          sel;
        logic [31:0] exp;
        int          id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] getq(int sel);
        case (sel)
            S_R1:    return bus.R1_q;
            S_R2:    return bus.R2_q;
            S_R3:    return bus.R3_q;
            S_PC:    return bus.PC_q;
            S_IR:    return bus.IR_q;
            S_MAR:   return bus.MAR_q;
            S_MDR:   return bus.MDR_q;
            S_Y:     return bus.Y_q;
            S_ZL:    return bus.Zlow_q;
            S_ZH:    return bus.Zhigh_q;
            default: return bus.BusMuxOut;
        endcase
    endfunction

    task automatic check(int id, int sel, logic [31:0] exp);
        logic [31:0] act;
        act = getq(sel);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d sel%0d got %h expected %h", id, sel, act, exp);
        end
    endtask

    task automatic drive(logic [16:0] ctrl, logic [31:0] md);
        {bus.PCout, bus.Zlowout, bus.MDRout, bus.R2out, bus.R3out, bus.MARin, bus.Zin,
         bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.R1in, bus.R2in, bus.R3in,
         bus.IncPC, bus.AND, bus.Read} = ctrl;
        bus.Mdatain = md;
    endtask

    task automatic add(logic [16:0] c, logic [31:0] md, int s1, logic [31:0] e1,
                       int s2 = NONE, logic [31:0] e2 = '0);
        vec_t v;
        v.ctrl = c; v.md = md; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
        vecs.push_back(v);
    endtask

    // Bus checks are combinational and taken before the edge; register checks go through the queue.
    task automatic run_vec(int id, vec_t v);
        sb_t e;
        @(negedge clock);
        drive(v.ctrl, v.md);
        #1;
        if (v.s1 == S_BUS) check(id, S_BUS, v.e1);
        else if (v.s1 != NONE) begin e.sel = v.s1; e.exp = v.e1; e.id = id; sbq.push_back(e); end
        if (v.s2 == S_BUS) check(id, S_BUS, v.e2);
        else if (v.s2 != NONE) begin e.sel = v.s2; e.exp = v.e2; e.id = id; sbq.push_back(e); end
        @(posedge clock);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.id, e.sel, e.exp);
        end
    endtask

    initial begin
        logic [31:0] cfg_exp;
`ifdef DATAPATH_ADD_EN
        cfg_exp = 32'd7;
`else
        cfg_exp = 32'd0;
`endif
        add(READ | MDRIN, 32'h12, S_MDR, 32'h12);
        add(MDROUT | R2IN, 32'h0, S_R2, 32'h12, S_BUS, 32'h12);
        add(READ | MDRIN, 32'h14, S_MDR, 32'h14);
        add(MDROUT | R3IN, 32'h0, S_R3, 32'h14);
        add(READ | MDRIN, 32'h18, S_MDR, 32'h18);
        add(MDROUT | R1IN, 32'h0, S_R1, 32'h18);
        add(PCOUT | MARIN | INCPC | ZIN, 32'h0, S_MAR, 32'h0, S_ZL, 32'h1);
        add(ZLOUT | PCIN | READ | MDRIN, 32'h28918000, S_PC, 32'h1, S_MDR, 32'h28918000);
        add(MDROUT | IRIN, 32'h0, S_IR, 32'h28918000);
        add(R2OUT | YIN, 32'h0, S_Y, 32'h12);
        add(R3OUT | ANDC | ZIN, 32'h0, S_ZL, 32'h10, S_ZH, 32'h0);
        add(ZLOUT | R1IN, 32'h0, S_R1, 32'h10);
        add(MDROUT | PCOUT | R2OUT | R3IN, 32'h0, S_BUS, 32'h28918000, S_R3, 32'h28918000);
        add(ZLOUT | MDROUT, 32'h0, S_BUS, 32'h10);
        add(17'd0, 32'h0, S_BUS, 32'h0, S_R1, 32'h10);
        add(PCOUT | PCIN | INCPC | ZIN, 32'h0, S_PC, 32'h1, S_ZL, 32'h2);
        add(READ | MDRIN, 32'hFFFFFFFF, S_MDR, 32'hFFFFFFFF);
        add(MDROUT | PCIN, 32'h0, S_PC, 32'hFFFFFFFF);
        add(PCOUT | INCPC | ZIN, 32'h0, S_ZL, 32'h0, S_ZH, 32'h0);
        add(READ | MDRIN, 32'h3, S_MDR, 32'h3);
        add(MDROUT | YIN, 32'h0, S_Y, 32'h3);
        add(READ | MDRIN, 32'h4, S_MDR, 32'h4);
        add(MDROUT | R2IN, 32'h0, S_R2, 32'h4);
        add(R2OUT | ZIN, 32'h0, S_BUS, 32'h4, S_ZL, cfg_exp);
        add(R2OUT | MDRIN, 32'hDEAD, S_MDR, 32'h4);
        add(R3OUT | ANDC | ZIN, 32'h0, S_ZL, 32'h0);

        clear = 0;
        drive(MDROUT, 32'h0);
        #12;
        for (int s = 0; s <= S_BUS; s++) check(0, s, 32'h0);
        @(negedge clock);
        clear = 1;
        for (int i = 0; i < vecs.size(); i++) run_vec(i + 1, vecs[i]);

        // Async clear mid-cycle with a pending MDR load, then resume on the next edge.
        @(negedge clock);
        drive(MDROUT | READ | MDRIN, 32'h55);
        #2 clear = 0;
        #1;
        for (int s = 0; s <= S_BUS; s++) check(100, s, 32'h0);
        @(posedge clock);
        #1 check(101, S_MDR, 32'h0);
        @(negedge clock);
        clear = 1;
        @(posedge clock);
        #1 check(102, S_MDR, 32'h55);
        check(103, S_BUS, 32'h55);

        @(negedge clock);
        drive(17'd0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
